keep_mode_sequencer: RTL and testbench
======================================

// Module: keep_mode_sequencer
// PURPOSE
//   Sequences the 4-entry mode selector that feeds the value/LED display datapath.
//   Steps through modes 0..3 on a dwell timer (auto mode) or on a button press.
//   Registers the selected mode, its 11-bit value and its 3-LED pattern.
//   Sits between the board button/switch inputs and the display/LED pins.
// PARAMETERS
//   DWELL_CYCLES  50_000_000  clk cycles per mode in auto mode (>=2)
//   DEB_CYCLES    1_000_000   stable cycles required by debounce (KEEP_DEBOUNCE_EN only)
// PORTS
//   clk       in   1   single system clock
//   rst       in   1   synchronous, active-high reset
//   btn_next  in   1   async push button, high = pressed; each press advances one mode
//   auto_en   in   1   level; 1 = advance on dwell timer expiry
//   hold      in   1   level; 1 = freeze mode and timer
//   sel       out  2   current mode index (drives datapath select)
//   value     out  11  mode value: 0->5, 1->10, 2->15, 3->20
//   led       out  3   pattern {LED2,LED1,LED0}: 0->001, 1->010, 2->100, 3->011
//   step      out  1   one-cycle pulse on the cycle sel changes
// BEHAVIOUR
//   Reset: state=IDLE, sel=0, value=0, led=000, step=0, timer=0, sync/edge flops=0.
//   btn_next: 2-flop synchroniser, then rising-edge detect -> press pulse (1 clk).
//   FSM (IDLE, SHOW, HOLD):
//     IDLE: outputs as reset. Press pulse or auto_en=1 -> SHOW with sel=0, value=5, led=001.
//       No step pulse on this entry.
//     SHOW: timer increments while auto_en=1. At timer==DWELL_CYCLES-1 -> advance, timer=0.
//       Press pulse -> advance immediately, timer=0. If expiry and press coincide, advance once.
//       hold=1 -> HOLD, with priority over advance in the same cycle.
//     HOLD: sel, value, led and timer are frozen. Press pulses are dropped.
//       hold=0 -> SHOW; the timer resumes from its frozen count.
//   Advance: sel <= sel+1 with wrap 3->0. value and led are loaded from the table for the new sel.
//     sel, value and led change on the same edge. step=1 for exactly that cycle.
//   auto_en=0 in SHOW: timer holds its count; only presses advance.
//   Latency: btn_next rise -> sel change on the 3rd rising clk edge (no debounce).
//   All outputs are registered. Arithmetic is unsigned. Timer width is $clog2(DWELL_CYCLES).
//   rst=1 in any state, including mid-dwell or in HOLD, returns to reset values on the next edge.
// CONFIGURATION
//   KEEP_DEBOUNCE_EN defined:
//     The synchronised button must be stable for DEB_CYCLES before the debounced level changes.
//     Edge detect runs on the debounced level. Latency = 3 + DEB_CYCLES cycles.
//     Glitches shorter than DEB_CYCLES produce no press.
//   KEEP_DEBOUNCE_EN undefined:
//     No debounce counter. DEB_CYCLES is unused. Every synchronised rising edge is a press.
// STRUCTURE
//   Package keep_pkg:
//     - typedef of the 2-bit mode type
//     - FSM state enum {IDLE, SHOW, HOLD}
//     - value lookup constants (5, 10, 15, 20)
//     - LED pattern constants (001, 010, 100, 011)
//   Sub-module keep_btn_cond:
//     - synchroniser, optional debounce and edge detect
//     - outputs a single-cycle press pulse
//   Top-level: FSM, dwell timer, output registers.
// TESTING  (sim: DWELL_CYCLES=8, DEB_CYCLES=4)
//   1. Reset release, auto_en=1:
//      -> next edge SHOW, sel=0/value=5/led=001.
//      -> sel=1/value=10/led=010 after 8 cycles, with step high for 1 cycle.
//   2. auto_en=1 for 40 cycles:
//      -> sel sequence 0,1,2,3,0. value 5,10,15,20,5. Wrap 3->0 asserts step.
//   3. auto_en=0, pulse btn_next in SHOW with sel=2:
//      -> sel=3, value=20, led=011 on the 3rd edge after the rise. Exactly one step.
//   4. Press coinciding with timer expiry (timer=7):
//      -> single advance, timer=0, one step pulse.
//   5. hold=1 at timer=5 for 20 cycles, pressing btn_next during hold:
//      -> outputs frozen, no step.
//      -> after hold=0, advance occurs 3 cycles later (timer 5->7->expiry).
//   6. rst=1 mid-dwell while in HOLD:
//      -> next edge IDLE, sel=0, value=0, led=000.
//      KEEP_DEBOUNCE_EN build: a 2-cycle btn glitch -> no advance.

Source files
------------

// File: rtl/keep_pkg.sv
// keep_pkg
//   Shared types and constants for the keep mode sequencer: the 2-bit mode
//   type, the sequencer FSM state encoding, and the per-mode value and LED
//   lookup tables. The tables are exposed both as named constants and as
//   lookup functions so the top level can load the output registers directly.
package keep_pkg;

  // Mode index that drives the downstream datapath select
  typedef logic [1:0] mode_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned VALUE_W = 11;
  localparam int unsigned LED_W   = 3;

  // Per-mode display values
  localparam logic [VALUE_W-1:0] VALUE_M0 = 11'd5;
  localparam logic [VALUE_W-1:0] VALUE_M1 = 11'd10;
  localparam logic [VALUE_W-1:0] VALUE_M2 = 11'd15;
  localparam logic [VALUE_W-1:0] VALUE_M3 = 11'd20;

  // Per-mode LED patterns, ordered {LED2,LED1,LED0}
  localparam logic [LED_W-1:0] LED_M0 = 3'b001;
  localparam logic [LED_W-1:0] LED_M1 = 3'b010;
  localparam logic [LED_W-1:0] LED_M2 = 3'b100;
  localparam logic [LED_W-1:0] LED_M3 = 3'b011;

  // Value lookup for a mode index
  function automatic logic [VALUE_W-1:0] mode_value(input mode_t m);
    logic [VALUE_W-1:0] v;
    case (m)
      2'd0:    v = VALUE_M0;
      2'd1:    v = VALUE_M1;
      2'd2:    v = VALUE_M2;
      2'd3:    v = VALUE_M3;
      default: v = VALUE_M0;
    endcase
    return v;
  endfunction

  // LED pattern lookup for a mode index
  function automatic logic [LED_W-1:0] mode_led(input mode_t m);
    logic [LED_W-1:0] l;
    case (m)
      2'd0:    l = LED_M0;
      2'd1:    l = LED_M1;
      2'd2:    l = LED_M2;
      2'd3:    l = LED_M3;
      default: l = LED_M0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/keep_btn_cond.sv
// keep_btn_cond
//   Conditions the asynchronous push button into a single-cycle press pulse:
//   2-flop synchroniser, optional debounce, rising-edge detect.
//   Optional feature macro: KEEP_DEBOUNCE_EN
//     defined   -> the synchronised level must be stable for DEB_CYCLES clocks
//                  before the debounced level follows it; edges are taken on
//                  the debounced level.
//     undefined -> every synchronised rising edge is a press.
// Ports
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   btn_i    in  1  raw asynchronous button, high = pressed
//   press_o  out 1  one-cycle pulse per press (combinational from flops)
module keep_btn_cond #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  // A zero-length debounce window is meaningless in either build
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("keep_btn_cond: DEB_CYCLES must be at least 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level_s;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEEP_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             deb_q;
  logic             deb_d;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;

  // Count consecutive cycles the synchronised level disagrees with the
  // debounced level; any agreement restarts the window, so short glitches
  // never reach the edge detector.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign level_s = deb_q;
`else
  assign level_s = sync2_q;
`endif

  // Previous conditioned level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  assign press_o = level_s & ~prev_q;

endmodule

// File: rtl/keep_mode_sequencer.sv
// keep_mode_sequencer
//   Steps a 4-entry mode selector (0..3, wrapping) either on a dwell timer
//   (auto_en) or on button presses, and registers the selected mode, its
//   11-bit display value and its 3-LED pattern.
//   Optional feature macro: KEEP_DEBOUNCE_EN (button debounce, see
//   keep_btn_cond).
// Ports
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset
//   btn_next  in  1   async push button, each press advances one mode
//   auto_en   in  1   advance on dwell timer expiry
//   hold      in  1   freeze mode and timer
//   sel       out 2   current mode index
//   value     out 11  mode value (5/10/15/20), 0 while idle
//   led       out 3   mode LED pattern {LED2,LED1,LED0}, 000 while idle
//   step      out 1   one-cycle pulse on the cycle sel changes
module keep_mode_sequencer
  import keep_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned DEB_CYCLES   = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_next,
  input  logic               auto_en,
  input  logic               hold,
  output logic [1:0]         sel,
  output logic [VALUE_W-1:0] value,
  output logic [LED_W-1:0]   led,
  output logic               step
);

  // The wrap compare needs at least two distinct timer values
  if (DWELL_CYCLES < 2) begin : g_bad_dwell_cycles
    $error("keep_mode_sequencer: DWELL_CYCLES must be at least 2");
  end

  localparam int unsigned TIMER_W = $clog2(DWELL_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DWELL_CYCLES - 1);

  logic               press_s;
  logic               expire_s;
  mode_t              next_sel_s;

  state_e             state_q, state_d;
  mode_t              sel_q, sel_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               step_q, step_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  keep_btn_cond #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_cond (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_next),
    .press_o (press_s)
  );

  assign expire_s   = auto_en && (timer_q == TIMER_LAST);
  assign next_sel_s = sel_q + 2'd1;

  // Next-state and output-register logic for the sequencer FSM
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    value_d = value_q;
    led_d   = led_q;
    step_d  = 1'b0;
    timer_d = timer_q;

    case (state_q)
      IDLE: begin
        if (press_s || auto_en) begin
          // Entering SHOW loads mode 0 without a step pulse
          state_d = SHOW;
          sel_d   = 2'd0;
          value_d = mode_value(2'd0);
          led_d   = mode_led(2'd0);
          timer_d = '0;
        end else begin
          state_d = IDLE;
          sel_d   = 2'd0;
          value_d = '0;
          led_d   = '0;
          timer_d = '0;
        end
      end

      SHOW: begin
        if (hold) begin
          // hold wins over a same-cycle advance; everything freezes
          state_d = HOLD;
        end else if (press_s || expire_s) begin
          // Coincident press and expiry collapse into one advance
          state_d = SHOW;
          sel_d   = next_sel_s;
          value_d = mode_value(next_sel_s);
          led_d   = mode_led(next_sel_s);
          step_d  = 1'b1;
          timer_d = '0;
        end else if (auto_en) begin
          state_d = SHOW;
          timer_d = timer_q + 1'b1;
        end else begin
          state_d = SHOW;
        end
      end

      HOLD: begin
        if (hold) begin
          state_d = HOLD;
        end else if (expire_s) begin
          // The release cycle already counts as a running cycle, so a timer
          // frozen at its last value expires right away. Presses stay dropped.
          state_d = SHOW;
          sel_d   = next_sel_s;
          value_d = mode_value(next_sel_s);
          led_d   = mode_led(next_sel_s);
          step_d  = 1'b1;
          timer_d = '0;
        end else if (auto_en) begin
          state_d = SHOW;
          timer_d = timer_q + 1'b1;
        end else begin
          state_d = SHOW;
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        value_d = '0;
        led_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      value_q <= '0;
      led_q   <= '0;
      step_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      value_q <= value_d;
      led_q   <= led_d;
      step_q  <= step_d;
      timer_q <= timer_d;
    end
  end

  assign sel   = sel_q;
  assign value = value_q;
  assign led   = led_q;
  assign step  = step_q;

endmodule

// File: tb/tb_keep_mode_sequencer.sv
// tb_keep_mode_sequencer
//   Directed bench for keep_mode_sequencer with DWELL_CYCLES=8, DEB_CYCLES=4
//   (default build, no debounce). Inputs change 1 time unit after a rising
//   edge; outputs are sampled at that same point.
module tb_keep_mode_sequencer;

  logic        clk;
  logic        rst;
  logic        btn_next;
  logic        auto_en;
  logic        hold;
  logic [1:0]  sel;
  logic [10:0] value;
  logic [2:0]  led;
  logic        step;

  int n_cmp;
  int n_err;

  // Expected per-mode tables, written out by hand
  logic [10:0] exp_val [4];
  logic [2:0]  exp_led [4];

  keep_mode_sequencer #(
    .DWELL_CYCLES (8),
    .DEB_CYCLES   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .auto_en  (auto_en),
    .hold     (hold),
    .sel      (sel),
    .value    (value),
    .led      (led),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mode(input string tag, input logic [1:0] m, input logic stp);
    chk({tag, ".sel"},   32'(sel),   32'(m));
    chk({tag, ".value"}, 32'(value), 32'(exp_val[m]));
    chk({tag, ".led"},   32'(led),   32'(exp_led[m]));
    chk({tag, ".step"},  32'(step),  32'(stp));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sel"},   32'(sel),   32'd0);
    chk({tag, ".value"}, 32'(value), 32'd0);
    chk({tag, ".led"},   32'(led),   32'd0);
    chk({tag, ".step"},  32'(step),  32'd0);
  endtask

  // Press and release the button while auto_en=0; sel moves on the 3rd edge
  task automatic press_adv(input string tag, input logic [1:0] new_sel);
    logic [1:0] old_sel;
    old_sel = new_sel - 2'd1;
    btn_next = 1'b1;
    tick();
    tick();
    chk({tag, ".before"}, 32'(sel), 32'(old_sel));
    tick();
    chk_mode({tag, ".adv"}, new_sel, 1'b1);
    btn_next = 1'b0;
    tick();
    chk({tag, ".step_low"}, 32'(step), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_val[0] = 11'd5;  exp_led[0] = 3'b001;
    exp_val[1] = 11'd10; exp_led[1] = 3'b010;
    exp_val[2] = 11'd15; exp_led[2] = 3'b100;
    exp_val[3] = 11'd20; exp_led[3] = 3'b011;

    rst      = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    hold     = 1'b0;
    repeat (3) tick();
    chk_idle("reset");

    // Out of reset with no request the sequencer stays idle
    rst = 1'b0;
    tick();
    tick();
    chk_idle("idle_wait");

    // 1. auto_en -> SHOW mode 0 on the next edge, mode 1 eight edges later
    auto_en = 1'b1;
    tick();
    chk_mode("t1_enter", 2'd0, 1'b0);
    repeat (7) tick();
    chk_mode("t1_dwell", 2'd0, 1'b0);
    tick();
    chk_mode("t1_adv", 2'd1, 1'b1);
    tick();
    chk("t1_step_one", 32'(step), 32'd0);

    // 2. continue through 2, 3 and the wrap back to 0
    for (int k = 2; k <= 4; k++) begin
      logic [1:0] m;
      logic [1:0] prev_m;
      m = 2'(k);
      prev_m = m - 2'd1;
      repeat (6) tick();
      chk_mode("t2_dwell", prev_m, 1'b0);
      tick();
      chk_mode("t2_adv", m, 1'b1);
      tick();
    end
    // one extra tick above already consumed; timer now at 1 in mode 0
    // 3. manual presses with auto_en off
    auto_en = 1'b0;
    tick();
    press_adv("t3_p1", 2'd1);
    press_adv("t3_p2", 2'd2);
    press_adv("t3_p3", 2'd3);
    repeat (10) tick();
    chk_mode("t3_no_auto", 2'd3, 1'b0);

    // 4. press lands on the expiry cycle (timer was cleared by the last press)
    auto_en = 1'b1;
    repeat (5) tick();
    btn_next = 1'b1;
    tick();
    tick();
    chk("t4_before", 32'(sel), 32'd3);
    tick();
    chk_mode("t4_adv", 2'd0, 1'b1);
    btn_next = 1'b0;
    repeat (7) tick();
    chk_mode("t4_single", 2'd0, 1'b0);
    tick();
    chk_mode("t4_next", 2'd1, 1'b1);

    // 5. hold at timer=5 for 20 cycles, with a press inside the hold
    repeat (5) tick();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) btn_next = 1'b1;
      if (i == 8) btn_next = 1'b0;
      tick();
      chk("t5_hold.sel", 32'(sel), 32'd1);
      chk("t5_hold.step", 32'(step), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("t5_r1", 32'(sel), 32'd1);
    tick();
    chk_mode("t5_r2", 2'd1, 1'b0);
    tick();
    chk_mode("t5_r3", 2'd2, 1'b1);

    // 6. reset while in HOLD mid-dwell
    repeat (3) tick();
    hold = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_idle("t6_rst");
    rst     = 1'b0;
    hold    = 1'b0;
    auto_en = 1'b0;
    tick();
    chk_idle("t6_idle");
    auto_en = 1'b1;
    tick();
    chk_mode("t6_enter", 2'd0, 1'b0);
    repeat (7) tick();
    chk_mode("t6_dwell", 2'd0, 1'b0);
    tick();
    chk_mode("t6_adv", 2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
